led_fade_driver: RTL and testbench

LED_FADE_DRIVER -- requirements
Module: led_fade_driver

---
 rtl/led_fade_driver.sv | 136 +++++++++++++
 tb/tb_led_fade_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// Four-channel LED fader: PWM-driven levels step toward a 4-bit on/off pattern, one step per prescaler tick.
// Latency: an accepted pattern loads target on the accept edge; led is registered one cycle after level.
// Backpressure: pat_ready drops while a pattern is buffered during a fade (one-deep pending slot).
module led_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 23437
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pat,
  input  logic       pat_valid,
  output logic       pat_ready,
  output logic [3:0] led,
  output logic       busy
);

  localparam int PW   = PWM_BITS;
  localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]   LVL_MAX = '1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [PW-1:0]   level_q [4];
  logic [PW-1:0]   level_d [4];
  logic [3:0]      target_q, target_d;
  logic [3:0]      pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [3:0]      led_q, led_d;

  logic tick;
  logic accept;
  logic all_at_target;

  assign tick      = (presc_q == PS_LAST);
  assign pat_ready = !pend_full_q;
  assign accept    = pat_valid && pat_ready;
  assign busy      = (state_q == FADING);
  assign led       = led_q;

  // Free-running PWM counter and fade-step prescaler.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PW'(1);
    presc_d   = tick ? '0 : presc_q + PS_W'(1);
  end

  // Step each level one unit toward its all-ones/zero target on a tick; saturates at the target, so never wraps.
  always_comb begin
    all_at_target = 1'b1;
    for (int i = 0; i < 4; i++) begin
      level_d[i] = level_q[i];
      if (tick) begin
        if (level_q[i] < {PW{target_q[i]}}) begin
          level_d[i] = level_q[i] + PW'(1);
        end else if (level_q[i] > {PW{target_q[i]}}) begin
          level_d[i] = level_q[i] - PW'(1);
        end
      end
      if (level_d[i] != {PW{target_q[i]}}) begin
        all_at_target = 1'b0;
      end
    end
  end

  // PWM compare; full level forces the output on so all-ones is a constant 1 rather than 255/256.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      led_d[i] = (pwm_cnt_q < level_q[i]) || (level_q[i] == LVL_MAX);
    end
  end

  // FSM next state: IDLE loads new targets directly, FADING parks one pattern and drains it when the fade lands.
  // Accept and drain cannot coincide: accept needs pend_full_q = 0, drain needs pend_full_q = 1.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (pat != target_q)) begin
          target_d = pat;
          state_d  = FADING;
        end
      end
      FADING: begin
        if (accept) begin
          pend_d      = pat;
          pend_full_d = 1'b1;
        end else if (all_at_target) begin
          if (pend_full_q) begin
            target_d    = pend_q;
            pend_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any fade in progress and the pending pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pwm_cnt_q   <= '0;
      presc_q     <= '0;
      target_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      led_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pwm_cnt_q   <= pwm_cnt_d;
      presc_q     <= presc_d;
      target_q    <= target_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      led_q       <= led_d;
      for (int i = 0; i < 4; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: vector table for idle behaviour plus hand-written fade sequences.
// A second instance with a slow prescaler holds a mid-scale level long enough to measure PWM duty.
// All expected values are hand-computed constants or cycle-count windows.
module tb_led_fade_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] pat;
  logic       pat_valid;
  logic       pat_ready;
  logic [3:0] led;
  logic       busy;

  logic       rst2_n;
  logic [3:0] pat2;
  logic       pat2_valid;
  logic       pat2_ready;
  logic [3:0] led2;
  logic       busy2;

  int checks;
  int errors;

  led_fade_driver #(.PWM_BITS(8), .STEP_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pat       (pat),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .led       (led),
    .busy      (busy)
  );

  led_fade_driver #(.PWM_BITS(8), .STEP_DIV(400)) dut_duty (
    .clk       (clk),
    .rst_n     (rst2_n),
    .pat       (pat2),
    .pat_valid (pat2_valid),
    .pat_ready (pat2_ready),
    .led       (led2),
    .busy      (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] pat;
    logic       vld;
    logic       exp_busy;
    logic       exp_rdy;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    int n;
    int m;
    int bad;
    int bad2;
    int highs;

    checks = 0;
    errors = 0;

    // idle vectors: nothing changes target 0000 except a differing valid pattern
    vecs[0] = '{pat: 4'b0000, vld: 1'b1, exp_busy: 1'b0, exp_rdy: 1'b1, exp_led: 4'b0000};
    vecs[1] = '{pat: 4'b0110, vld: 1'b0, exp_busy: 1'b0, exp_rdy: 1'b1, exp_led: 4'b0000};
    vecs[2] = '{pat: 4'b1111, vld: 1'b0, exp_busy: 1'b0, exp_rdy: 1'b1, exp_led: 4'b0000};
    vecs[3] = '{pat: 4'b0000, vld: 1'b1, exp_busy: 1'b0, exp_rdy: 1'b1, exp_led: 4'b0000};

    rst_n      = 1'b0;
    pat        = 4'b0000;
    pat_valid  = 1'b0;
    rst2_n     = 1'b0;
    pat2       = 4'b0000;
    pat2_valid = 1'b0;

    // reset state
    #2;
    check("reset led", {28'd0, led}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset pat_ready", {31'd0, pat_ready}, 32'd1);
    #20;
    rst_n = 1'b1;

    // quiet idle: led stays dark with no input
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #1;
      if (led !== 4'b0000 || busy !== 1'b0) bad++;
    end
    check("idle 1024 cycles dark", bad, 0);

    // table: consuming an equal pattern and ignoring unqualified ones
    for (int v = 0; v < 4; v++) begin
      pat       = vecs[v].pat;
      pat_valid = vecs[v].vld;
      @(posedge clk); #1;
      check($sformatf("vec%0d busy", v), {31'd0, busy}, {31'd0, vecs[v].exp_busy});
      check($sformatf("vec%0d pat_ready", v), {31'd0, pat_ready}, {31'd0, vecs[v].exp_rdy});
      check($sformatf("vec%0d led", v), {28'd0, led}, {28'd0, vecs[v].exp_led});
    end
    pat_valid = 1'b0;

    // fade channel 0 fully on: 255 ticks of 4 cycles, first tick phase unknown
    pat       = 4'b0001;
    pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    check("fade up busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_range("fade up duration", n, 1017, 1020);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (led !== 4'b0001) bad++;
    end
    check("full-on led constant 0001", bad, 0);

    // mid-fade buffering: 0010 parked, 0100 held off until the fade lands
    pat       = 4'b0000;
    pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    check("fade down busy", {31'd0, busy}, 32'd1);
    check("fade down ready", {31'd0, pat_ready}, 32'd1);
    n = 0;
    repeat (100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid-fade ready before send", {31'd0, pat_ready}, 32'd1);
    pat       = 4'b0010;
    pat_valid = 1'b1;
    @(posedge clk); #1;
    n++;
    check("pending accepted ready low", {31'd0, pat_ready}, 32'd0);
    pat = 4'b0100;
    bad = 0;
    while (pat_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (busy !== 1'b1) bad++;
    end
    check("busy held while pending", bad, 0);
    check_range("drain after fade down", n, 1017, 1020);
    check("busy after drain", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("second pattern buffered", {31'd0, pat_ready}, 32'd0);
    pat_valid = 1'b0;
    // drain edge sits on a tick, so both remaining fades are exactly 1020 cycles each
    m = 0;
    while (busy === 1'b1 && m < 4000) begin
      @(posedge clk); #1;
      m++;
    end
    check("chained fade duration", m, 2039);
    check("ready after chain", {31'd0, pat_ready}, 32'd1);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (led !== 4'b0100) bad++;
    end
    check("final led constant 0100", bad, 0);

    // asynchronous reset mid-fade with a pending pattern
    pat       = 4'b0001;
    pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    pat       = 4'b1111;
    pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    check("pre-reset pend full", {31'd0, pat_ready}, 32'd0);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async reset led", {28'd0, led}, 32'd0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset pat_ready", {31'd0, pat_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad  = 0;
    bad2 = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (led !== 4'b0000) bad++;
      if (busy !== 1'b0 || pat_ready !== 1'b1) bad2++;
    end
    check("post-reset led dark", bad, 0);
    check("post-reset idle", bad2, 0);

    // duty: level0 = 64 between edges 25600 and 26000 after acceptance
    @(negedge clk);
    rst2_n     = 1'b1;
    pat2       = 4'b0001;
    pat2_valid = 1'b1;
    @(posedge clk); #1;
    pat2_valid = 1'b0;
    repeat (25698) @(posedge clk);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (led2[0] === 1'b1) highs++;
    end
    check("duty level 64 high cycles", highs, 64);
    check("duty other channels dark", {28'd0, led2 & 4'b1110}, 32'd0);
    check("duty busy", {31'd0, busy2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
